// File: rtl/cpu_irq_ctrl.sv
// ============================================================================
// Module   : cpu_irq_ctrl
// Purpose  : RP2A03 interrupt sequencer - syncs NMI/IRQ pins, arbitrates
//            reset/NMI/BRK/IRQ and holds one latched request until acked.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_irq_ctrl #(
    parameter int unsigned              N_IRQ   = 4,
    parameter int unsigned              ADDR_W  = 16,
    parameter logic [ADDR_W-1:0]        NMI_VEC = 16'hFFFA,
    parameter logic [ADDR_W-1:0]        RST_VEC = 16'hFFFC,
    parameter logic [ADDR_W-1:0]        IRQ_VEC = 16'hFFFE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              nmi_n,
    input  logic [N_IRQ-1:0]  irq_n,
    input  logic [N_IRQ-1:0]  irq_mask,
    input  logic              i_flag,
    input  logic              instr_boundary,
    input  logic              brk_req,
    input  logic              int_ack,
    output logic              int_req,
    output logic [1:0]        int_kind,
    output logic [ADDR_W-1:0] int_vec,
    output logic              set_b,
    output logic              nmi_pending,
    output logic [N_IRQ-1:0]  irq_pending
);

    localparam logic [1:0] c_KIND_RST = 2'd0;
    localparam logic [1:0] c_KIND_NMI = 2'd1;
    localparam logic [1:0] c_KIND_IRQ = 2'd2;
    localparam logic [1:0] c_KIND_BRK = 2'd3;

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_IDLE = 2'd1,
        S_REQ  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_nmi_s1;
    logic                r_nmi_s2;
    logic                r_nmi_d;
    logic [N_IRQ-1:0]    r_irq_s1;
    logic [N_IRQ-1:0]    r_irq_s2;
    logic                r_nmi_pending;
    logic [1:0]          r_kind;
    logic [ADDR_W-1:0]   r_vec;
    logic                r_set_b;
    logic [1:0]          w_kind_nxt;
    logic [ADDR_W-1:0]   w_vec_nxt;
    logic                w_set_b_nxt;
    logic                w_nmi_edge;
    logic                w_nmi_clr;
    logic [N_IRQ-1:0]    w_irq_pending;
    logic                w_irq_any;

    // Synchronisers idle high so leaving reset never looks like a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nmi_s1 <= 1'b1;
            r_nmi_s2 <= 1'b1;
            r_nmi_d  <= 1'b1;
            r_irq_s1 <= '1;
            r_irq_s2 <= '1;
        end else begin
            r_nmi_s1 <= nmi_n;
            r_nmi_s2 <= r_nmi_s1;
            r_nmi_d  <= r_nmi_s2;
            r_irq_s1 <= irq_n;
            r_irq_s2 <= r_irq_s1;
        end
    end

    assign w_nmi_edge    = r_nmi_d & ~r_nmi_s2;
    assign w_nmi_clr     = (r_state == S_REQ) && int_ack && (r_kind == c_KIND_NMI);
    assign w_irq_pending = ~r_irq_s2 & irq_mask;
    assign w_irq_any     = (|w_irq_pending) & ~i_flag;

    // A new edge on the acknowledge cycle must not be lost: set dominates clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nmi_pending <= 1'b0;
        end else if (w_nmi_edge) begin
            r_nmi_pending <= 1'b1;
        end else if (w_nmi_clr) begin
            r_nmi_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RST;
            r_kind  <= c_KIND_RST;
            r_vec   <= RST_VEC;
            r_set_b <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_kind  <= w_kind_nxt;
            r_vec   <= w_vec_nxt;
            r_set_b <= w_set_b_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_kind_nxt  = r_kind;
        w_vec_nxt   = r_vec;
        w_set_b_nxt = r_set_b;
        case (r_state)
            S_RST: begin
                w_state_nxt = S_REQ;
                w_kind_nxt  = c_KIND_RST;
                w_vec_nxt   = RST_VEC;
                w_set_b_nxt = 1'b0;
            end
            S_IDLE: begin
                if (instr_boundary || brk_req) begin
                    if (r_nmi_pending) begin
                        // BRK in flight with a pending NMI is hijacked to the NMI vector.
                        w_state_nxt = S_REQ;
                        w_kind_nxt  = c_KIND_NMI;
                        w_vec_nxt   = NMI_VEC;
                        w_set_b_nxt = brk_req;
                    end else if (brk_req) begin
                        w_state_nxt = S_REQ;
                        w_kind_nxt  = c_KIND_BRK;
                        w_vec_nxt   = IRQ_VEC;
                        w_set_b_nxt = 1'b1;
                    end else if (w_irq_any && instr_boundary) begin
                        w_state_nxt = S_REQ;
                        w_kind_nxt  = c_KIND_IRQ;
                        w_vec_nxt   = IRQ_VEC;
                        w_set_b_nxt = 1'b0;
                    end
                end
            end
            S_REQ: begin
                if (int_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_RST;
            end
        endcase
    end

    assign int_req     = (r_state == S_REQ);
    assign int_kind    = r_kind;
    assign int_vec     = r_vec;
    assign set_b       = r_set_b;
    assign nmi_pending = r_nmi_pending;
    assign irq_pending = w_irq_pending;

endmodule

`default_nettype wire

// File: doc/cpu_irq_ctrl.md
# cpu_irq_ctrl

Parametrised interrupt sequencer for the RP2A03 CPU core. Synchronises the NMI pin and N maskable IRQ sources, detects NMI edges, arbitrates reset / NMI / BRK / IRQ by fixed priority, and presents the CPU state machine with one latched interrupt request carrying the following fields:

- kind, vector address and the B-flag value to push.

It sits between the APU/mapper/PPU interrupt lines and the core's decode logic. It replaces the hard-wired single-IRQ handling with per-source masking and BRK hijack support.

## Interface

- N_IRQ, 4, number of maskable IRQ sources (1..16)
- ADDR_W, 16, vector address width
- NMI_VEC, 16'hFFFA, NMI vector address
- RST_VEC, 16'hFFFC, reset vector address
- IRQ_VEC, 16'hFFFE, IRQ/BRK vector address

Ports:

- clk  in  1  system clock; all state on rising edge
- rst  in  1  reset: asynchronous, active-high
- nmi_n  in  1  NMI pin, active-low, asynchronous to clk
- irq_n  in  N_IRQ  IRQ lines, active-low level, asynchronous
- irq_mask  in  N_IRQ  per-source enable; 1 = source may interrupt
- i_flag  in  1  status register interrupt-disable bit
- instr_boundary  in  1  core is at an opcode-fetch boundary and can accept an interrupt
- brk_req  in  1  one-cycle pulse: core decoded BRK (8'h00)
- int_ack  in  1  core has fetched the vector; completes the request
- int_req  out  1  interrupt request, held until int_ack
- int_kind  out  2  0 = RESET, 1 = NMI, 2 = IRQ, 3 = BRK
- int_vec  out  ADDR_W  vector address for int_kind
- set_b  out  1  B bit value for the pushed status byte
- nmi_pending  out  1  latched NMI edge not yet serviced
- irq_pending  out  N_IRQ  synchronised, masked active IRQ sources

## Operation

- Synchronisers:
  - nmi_n and each irq_n pass through two flops.
  - All synchroniser flops reset to 1 (deasserted), so release from reset never produces a false edge.
- NMI edge detect:
  - A falling edge of synchronised nmi_n sets nmi_pending.
  - nmi_pending clears on the int_ack that completes a kind = NMI request.
  - If an edge is detected in the same cycle as that ack, nmi_pending stays 1 (set wins).
- IRQ:
  - Level-sensitive and not latched: irq_pending[i] = ~irq_sync[i] & irq_mask[i].
  - irq_any = |irq_pending & ~i_flag.
- FSM states:
  - S_RST: entered asynchronously on rst.
  - S_IDLE: waits for an interrupt to accept.
  - S_REQ: holds the latched request until acknowledged.
- S_RST -> S_REQ on the first clock edge with rst low. Latches kind = RESET, int_vec = RST_VEC, set_b = 0.
- S_IDLE: evaluates when instr_boundary = 1 or brk_req = 1, using fixed priority NMI > BRK > IRQ.
  - nmi_pending: kind NMI, NMI_VEC, set_b = 0.
  - brk_req with nmi_pending: BRK hijack. kind NMI, NMI_VEC, set_b = 1.
  - brk_req alone: kind BRK, IRQ_VEC, set_b = 1.
  - irq_any and instr_boundary: kind IRQ, IRQ_VEC, set_b = 0.
  - When any of these is taken, latch the fields and go to S_REQ. Otherwise stay in S_IDLE.
- S_REQ: int_req = 1 and the outputs are frozen. IRQ deassertion, i_flag changes and new brk_req are ignored. int_ack -> S_IDLE.
- int_ack outside S_REQ is ignored.
- brk_req while in S_REQ is dropped. The core must not issue BRK while int_req = 1.

## Timing

- Reset values:
  - int_req 0, int_kind 0, int_vec RST_VEC, set_b 0.
  - nmi_pending 0, irq_pending 0.
  - FSM in S_RST.
- Reset request: int_req rises after the first clock edge with rst low. rst reasserted mid-request drops int_req asynchronously and restarts at S_RST.
- NMI latency:
  - nmi_n low sampled at edge k sets nmi_pending after edge k+2.
  - int_req rises after the next edge on which instr_boundary = 1, at the earliest edge k+3.
- IRQ latency: irq_n low sampled at edge k -> irq_pending after edge k+1 -> int_req after the next boundary edge.
- BRK: brk_req at edge k -> int_req = 1 after edge k.
- Handshake:
  - int_req falls after the edge at which int_ack = 1.
  - The FSM can re-request after the following edge, so there is a minimum of one idle cycle between requests.
- Output registers: int_kind, int_vec and set_b are registered and change only on the S_IDLE -> S_REQ / S_RST -> S_REQ transitions.

## Test plan

- Reset: release rst -> after 1 edge int_req = 1, int_kind = 0, int_vec = 16'hFFFC. Pulse int_ack -> int_req = 0 on the next edge.
- NMI:
  - Stimulus: pulse nmi_n low for 1 cycle with instr_boundary = 1.
  - nmi_pending rises 2 edges later, then int_req with kind 1, vec 16'hFFFA.
  - After int_ack, nmi_pending = 0. Holding nmi_n low gives no second request.
- IRQ masking:
  - Stimulus: irq_n = 4'b1011, irq_mask = 4'b0100, i_flag = 1.
  - No request; irq_pending = 4'b0100.
  - Drop i_flag -> kind 2, vec 16'hFFFE, set_b = 0.
  - irq_mask = 4'b0000 -> no request.
- BRK hijack:
  - brk_req with nmi_pending = 0 -> kind 3, 16'hFFFE, set_b = 1.
  - brk_req with nmi_pending = 1 -> kind 1, 16'hFFFA, set_b = 1.
- Simultaneous events:
  - NMI edge detected on the ack cycle of an NMI request -> nmi_pending stays 1 and a second NMI request follows.
  - IRQ released during S_REQ -> outputs unchanged until ack.
- Reset mid-request: assert rst while int_req = 1 -> int_req = 0 immediately (asynchronous); outputs return to reset values.
